// File: rtl/exec_csr_pkg.sv
// Shared constants for the machine-mode CSR file: privilege levels, trap
// cause codes, CSR addresses and mstatus bit positions.
package priv_levels;
  localparam logic [1:0] PRIV_M = 2'b11;
endpackage

package trap_causes;
  localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;
endpackage

package csr_addrs;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
endpackage

// File: rtl/exec_csr_counter.sv
// Free-running counter with increment enable and a write port; a write in
// the same cycle replaces the increment. Wraps from all-ones to zero.
module csr_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         we_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;

  // NOTE: default first so every path assigns count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (we_i)       count_d = wdata_i;
    else if (inc_i) count_d = count_q + W'(1);
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/exec_csr.sv
// Machine-mode CSR file and Zicsr execution unit: combinational read/illegal
// decode, registered CSR writes, trap entry and MRET state updates.
module exec_csr
  import priv_levels::*;
  import trap_causes::*;
  import csr_addrs::*;
#(
  parameter int              XLEN        = 64,
  parameter int              ALEN        = XLEN,
  parameter logic [XLEN-1:0] HART_ID     = '0,
  parameter logic [XLEN-1:0] MISA_VALUE  = 64'h8000000000141101,
  parameter logic [ALEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_instr_valid,
  input  logic [11:0]     csr_addr,
  input  logic [2:0]      csr_funct3,
  input  logic [4:0]      csr_rd,
  input  logic [4:0]      csr_rs1_uimm,
  input  logic [XLEN-1:0] csr_rs1_data,
  output logic            csr_exception,
  output logic [3:0]      csr_trap_cause,
  output logic [XLEN-1:0] csr_result,
  input  logic            trap_valid,
  input  logic            trap_is_interrupt,
  input  logic [3:0]      trap_cause,
  input  logic [ALEN-1:0] trap_epc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            xret_valid,
  input  logic [XLEN-1:0] xret_new_mstatus,
  input  logic [1:0]      xret_new_priv,
  input  logic            instret_pulse,
  input  logic            timer_irq,
  output logic [1:0]      privilege_mode,
  output logic [XLEN-1:0] mstatus,
  output logic [XLEN-1:0] mie,
  output logic [XLEN-1:0] mip,
  output logic [ALEN-1:0] mepc,
  output logic [ALEN-1:0] mtvec
);
  localparam logic [XLEN-1:0] MSTATUS_MASK = (XLEN'(1) << MSTATUS_MIE) | (XLEN'(1) << MSTATUS_MPIE)
                                           | (XLEN'(3) << MSTATUS_MPP_LO);
  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);
  localparam logic [ALEN-1:0] PC_MASK  = {{(ALEN-2){1'b1}}, 2'b00};

  logic [1:0]      priv_q, priv_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d, mie_q, mie_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic [ALEN-1:0] mepc_q, mepc_d, mtvec_q, mtvec_d;
  logic [XLEN-1:0] mcycle_w, minstret_w, mip_w;
  logic [XLEN-1:0] old_val, src, wval;
  logic            implemented, write_attempt, illegal, do_write;
  logic            unused_rd;

  assign unused_rd = ^csr_rd;
  assign mip_w     = XLEN'(timer_irq) << 7;

  // An MPP of 10 (reserved) leaves the previous MPP in place.
  function automatic logic [XLEN-1:0] legal_mstatus(input logic [XLEN-1:0] nv,
                                                    input logic [XLEN-1:0] ov);
    logic [XLEN-1:0] r;
    r = nv & MSTATUS_MASK;
    if (r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == 2'b10)
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = ov[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
    return r;
  endfunction

  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:               old_val = mstatus_q;
      CSR_MISA:                  old_val = MISA_VALUE;
      CSR_MIE:                   old_val = mie_q;
      CSR_MTVEC:                 old_val = XLEN'(mtvec_q);
      CSR_MSCRATCH:              old_val = mscratch_q;
      CSR_MEPC:                  old_val = XLEN'(mepc_q);
      CSR_MCAUSE:                old_val = mcause_q;
      CSR_MTVAL:                 old_val = mtval_q;
      CSR_MIP:                   old_val = mip_w;
      CSR_MCYCLE, CSR_CYCLE:     old_val = mcycle_w;
      CSR_MINSTRET, CSR_INSTRET: old_val = minstret_w;
      CSR_MHARTID:               old_val = HART_ID;
      default:                   implemented = 1'b0;
    endcase
  end

  // RW/RWI always write; set/clear forms write only with a non-zero rs1/uimm.
  assign write_attempt = (csr_funct3[1:0] == 2'b01) ||
                         ((csr_funct3[1:0] != 2'b00) && (csr_rs1_uimm != 5'd0));
  assign illegal = csr_instr_valid && (!implemented || (csr_addr[9:8] > priv_q) ||
                                       ((csr_addr[11:10] == 2'b11) && write_attempt));
  assign do_write = csr_instr_valid && write_attempt && !illegal;
  assign src      = csr_funct3[2] ? XLEN'(csr_rs1_uimm) : csr_rs1_data;

  always_comb begin
    case (csr_funct3[1:0])
      2'b01:   wval = src;
      2'b10:   wval = old_val | src;
      2'b11:   wval = old_val & ~src;
      default: wval = old_val;
    endcase
  end

  assign csr_exception  = illegal;
  assign csr_trap_cause = EXC_ILLEGAL_INSTR;
  assign csr_result     = csr_instr_valid ? old_val : '0;

  // Later assignments win: trap entry over MRET over the CSR write.
  always_comb begin
    priv_d     = priv_q;
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (do_write) begin
      case (csr_addr)
        CSR_MSTATUS:  mstatus_d  = legal_mstatus(wval, mstatus_q);
        CSR_MIE:      mie_d      = wval & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = ALEN'(wval) & PC_MASK;
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = ALEN'(wval) & PC_MASK;
        CSR_MCAUSE:   mcause_d   = wval;
        CSR_MTVAL:    mtval_d    = wval;
        default:      ;
      endcase
    end
    if (xret_valid) begin
      mstatus_d = xret_new_mstatus & MSTATUS_MASK;
      priv_d    = xret_new_priv;
    end
    if (trap_valid) begin
      mepc_d   = trap_epc & PC_MASK;
      mcause_d = {trap_is_interrupt, {(XLEN-5){1'b0}}, trap_cause};
      mtval_d  = trap_tval;
      mstatus_d = '0;
      mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_q;
      priv_d   = PRIV_M;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      priv_q     <= PRIV_M;
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      priv_q     <= priv_d;
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_counter #(.W(XLEN)) u_mcycle (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (1'b1),
    .we_i    (do_write && (csr_addr == CSR_MCYCLE)),
    .wdata_i (wval),
    .count_o (mcycle_w)
  );

  csr_counter #(.W(XLEN)) u_minstret (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (instret_pulse),
    .we_i    (do_write && (csr_addr == CSR_MINSTRET)),
    .wdata_i (wval),
    .count_o (minstret_w)
  );

  assign privilege_mode = priv_q;
  assign mstatus        = mstatus_q;
  assign mie            = mie_q;
  assign mip            = mip_w;
  assign mepc           = mepc_q;
  assign mtvec          = mtvec_q;
endmodule

// File: tb/tb_exec_csr.sv
// Directed bench for exec_csr: a vector table of single CSR operations in
// M-mode plus hand-written trap, MRET, counter and reset sequences.
module tb_exec_csr;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csr_instr_valid = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [2:0]  csr_funct3 = '0;
  logic [4:0]  csr_rd = '0;
  logic [4:0]  csr_rs1_uimm = '0;
  logic [63:0] csr_rs1_data = '0;
  logic        csr_exception;
  logic [3:0]  csr_trap_cause;
  logic [63:0] csr_result;
  logic        trap_valid = 1'b0;
  logic        trap_is_interrupt = 1'b0;
  logic [3:0]  trap_cause = '0;
  logic [63:0] trap_epc = '0;
  logic [63:0] trap_tval = '0;
  logic        xret_valid = 1'b0;
  logic [63:0] xret_new_mstatus = '0;
  logic [1:0]  xret_new_priv = '0;
  logic        instret_pulse = 1'b0;
  logic        timer_irq = 1'b0;
  logic [1:0]  privilege_mode;
  logic [63:0] mstatus, mie, mip, mepc, mtvec;

  localparam logic [63:0] MISA = 64'h8000000000141101;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_cycle;

  exec_csr dut (
    .clk(clk), .rst(rst), .csr_instr_valid(csr_instr_valid), .csr_addr(csr_addr),
    .csr_funct3(csr_funct3), .csr_rd(csr_rd), .csr_rs1_uimm(csr_rs1_uimm),
    .csr_rs1_data(csr_rs1_data), .csr_exception(csr_exception),
    .csr_trap_cause(csr_trap_cause), .csr_result(csr_result), .trap_valid(trap_valid),
    .trap_is_interrupt(trap_is_interrupt), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .trap_tval(trap_tval), .xret_valid(xret_valid), .xret_new_mstatus(xret_new_mstatus),
    .xret_new_priv(xret_new_priv), .instret_pulse(instret_pulse), .timer_irq(timer_irq),
    .privilege_mode(privilege_mode), .mstatus(mstatus), .mie(mie), .mip(mip),
    .mepc(mepc), .mtvec(mtvec)
  );

  always #5 clk = ~clk;

  // Reference cycle count: posedges since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) exp_cycle <= '0;
    else      exp_cycle <= exp_cycle + 64'd1;
  end

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  f3;
    logic [4:0]  uimm;
    logic [63:0] data;
    logic        exc;
    logic [63:0] res;
  } vec_t;

  localparam int NV = 26;
  vec_t vt [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one CSR op just after a posedge, check outputs at the negedge,
  // then let it commit on the next posedge.
  task automatic csr_op(input logic [11:0] a, input logic [2:0] f, input logic [4:0] u,
                        input logic [63:0] d, input logic exc, input logic [63:0] res,
                        input string name);
    csr_instr_valid = 1'b1;
    csr_addr = a; csr_funct3 = f; csr_rs1_uimm = u; csr_rs1_data = d;
    @(negedge clk);
    check({name, ".exc"}, 64'(csr_exception), 64'(exc));
    if (exc) check({name, ".cause"}, 64'(csr_trap_cause), 64'd2);
    else     check({name, ".result"}, csr_result, res);
    @(posedge clk); #1;
    csr_instr_valid = 1'b0;
  endtask

  task automatic reset_release();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    vt[0]  = '{12'h340, 3'b001, 5'd1, 64'hDEAD_BEEF, 1'b0, 64'h0};
    vt[1]  = '{12'h340, 3'b010, 5'd0, 64'h1, 1'b0, 64'hDEAD_BEEF};
    vt[2]  = '{12'h340, 3'b010, 5'd0, 64'h0, 1'b0, 64'hDEAD_BEEF};
    vt[3]  = '{12'h340, 3'b011, 5'd1, 64'hF, 1'b0, 64'hDEAD_BEEF};
    vt[4]  = '{12'h340, 3'b110, 5'd3, 64'hFFFF, 1'b0, 64'hDEAD_BEE0};
    vt[5]  = '{12'h340, 3'b111, 5'd1, 64'h0, 1'b0, 64'hDEAD_BEE3};
    vt[6]  = '{12'h340, 3'b010, 5'd0, 64'h0, 1'b0, 64'hDEAD_BEE2};
    vt[7]  = '{12'h300, 3'b001, 5'd1, '1, 1'b0, 64'h0};
    vt[8]  = '{12'h300, 3'b001, 5'd1, 64'h1000, 1'b0, 64'h1888};
    vt[9]  = '{12'h300, 3'b010, 5'd0, 64'h0, 1'b0, 64'h1800};
    vt[10] = '{12'h304, 3'b001, 5'd1, '1, 1'b0, 64'h0};
    vt[11] = '{12'h304, 3'b010, 5'd0, 64'h0, 1'b0, 64'h888};
    vt[12] = '{12'h305, 3'b001, 5'd1, 64'h8000_0003, 1'b0, 64'h0};
    vt[13] = '{12'h305, 3'b010, 5'd0, 64'h0, 1'b0, 64'h8000_0000};
    vt[14] = '{12'h301, 3'b001, 5'd1, 64'h0, 1'b0, MISA};
    vt[15] = '{12'h301, 3'b010, 5'd0, 64'h0, 1'b0, MISA};
    vt[16] = '{12'hF14, 3'b001, 5'd1, 64'h0, 1'b1, 64'h0};
    vt[17] = '{12'hF14, 3'b010, 5'd0, 64'h0, 1'b0, 64'h0};
    vt[18] = '{12'h7C0, 3'b010, 5'd0, 64'h0, 1'b1, 64'h0};
    vt[19] = '{12'hC00, 3'b001, 5'd1, 64'h5, 1'b1, 64'h0};
    vt[20] = '{12'h341, 3'b001, 5'd1, 64'h1237, 1'b0, 64'h0};
    vt[21] = '{12'h341, 3'b010, 5'd0, 64'h0, 1'b0, 64'h1234};
    vt[22] = '{12'h344, 3'b010, 5'd0, 64'h0, 1'b0, 64'h0};
    vt[23] = '{12'h342, 3'b010, 5'd0, 64'h0, 1'b0, 64'h0};
    vt[24] = '{12'h343, 3'b001, 5'd1, 64'h77, 1'b0, 64'h0};
    vt[25] = '{12'h343, 3'b010, 5'd0, 64'h0, 1'b0, 64'h77};

    repeat (2) @(posedge clk);
    #1;
    check("rst.priv", 64'(privilege_mode), 64'd3);
    check("rst.mtvec", mtvec, 64'h0);
    reset_release();

    for (int i = 0; i < NV; i++)
      csr_op(vt[i].addr, vt[i].f3, vt[i].uimm, vt[i].data, vt[i].exc, vt[i].res,
             $sformatf("vec%0d", i));
    check("mtvec.out", mtvec, 64'h8000_0000);
    check("mie.out", mie, 64'h888);

    // No request: result reads zero.
    csr_addr = 12'h340;
    @(negedge clk);
    check("idle.result", csr_result, 64'h0);
    check("idle.exc", 64'(csr_exception), 64'h0);
    @(posedge clk); #1;

    // Cycle alias with uimm=0 reads the live counter in M-mode.
    csr_instr_valid = 1'b1; csr_addr = 12'hC00; csr_funct3 = 3'b110; csr_rs1_uimm = 5'd0;
    @(negedge clk);
    check("cycle.exc", 64'(csr_exception), 64'h0);
    check("cycle.result", csr_result, exp_cycle);
    @(posedge clk); #1; csr_instr_valid = 1'b0;

    // Trap coincident with an mepc write: the trap wins.
    csr_op(12'h300, 3'b001, 5'd1, 64'h8, 1'b0, 64'h1800, "set_mie");
    trap_valid = 1'b1; trap_cause = 4'd3; trap_epc = 64'h1002; trap_tval = 64'h55;
    csr_op(12'h341, 3'b001, 5'd1, 64'hAAA0, 1'b0, 64'h1234, "trap_wr");
    trap_valid = 1'b0;
    check("trap.mepc", mepc, 64'h1000);
    check("trap.mstatus", mstatus, 64'h1880);
    check("trap.priv", 64'(privilege_mode), 64'd3);
    csr_op(12'h342, 3'b010, 5'd0, 64'h0, 1'b0, 64'h3, "trap.mcause");
    csr_op(12'h343, 3'b010, 5'd0, 64'h0, 1'b0, 64'h55, "trap.mtval");

    // MRET to U-mode coincident with an mstatus write: MRET wins.
    xret_valid = 1'b1; xret_new_mstatus = 64'hFFFF_FFFF_FFFF_E77F; xret_new_priv = 2'b00;
    csr_op(12'h300, 3'b001, 5'd1, 64'h1888, 1'b0, 64'h1880, "xret_wr");
    xret_valid = 1'b0;
    check("xret.mstatus", mstatus, 64'h8);
    check("xret.priv", 64'(privilege_mode), 64'd0);
    csr_op(12'h300, 3'b010, 5'd0, 64'h0, 1'b1, 64'h0, "u.mstatus");
    check("u.mstatus_kept", mstatus, 64'h8);
    csr_op(12'h340, 3'b001, 5'd1, 64'h9, 1'b1, 64'h0, "u.mscratch");
    csr_op(12'hB00, 3'b010, 5'd0, 64'h0, 1'b1, 64'h0, "u.mcycle");
    csr_instr_valid = 1'b1; csr_addr = 12'hC00; csr_funct3 = 3'b110; csr_rs1_uimm = 5'd0;
    @(negedge clk);
    check("u.cycle.exc", 64'(csr_exception), 64'h0);
    check("u.cycle.result", csr_result, exp_cycle);
    @(posedge clk); #1; csr_instr_valid = 1'b0;
    csr_op(12'hC00, 3'b001, 5'd1, 64'h0, 1'b1, 64'h0, "u.cycle_wr");

    // Interrupt trap from U-mode.
    trap_valid = 1'b1; trap_is_interrupt = 1'b1; trap_cause = 4'd7; trap_epc = 64'h2000;
    @(posedge clk); #1;
    trap_valid = 1'b0; trap_is_interrupt = 1'b0;
    check("irq.mstatus", mstatus, 64'h80);
    check("irq.priv", 64'(privilege_mode), 64'd3);
    csr_op(12'h342, 3'b010, 5'd0, 64'h0, 1'b0, 64'h8000_0000_0000_0007, "irq.mcause");

    // Counter wrap and write-over-increment.
    csr_op(12'hB00, 3'b001, 5'd1, '1, 1'b0, exp_cycle, "mcycle_wr");
    csr_op(12'hB00, 3'b010, 5'd0, 64'h0, 1'b0, '1, "mcycle_ones");
    csr_op(12'hB00, 3'b010, 5'd0, 64'h0, 1'b0, 64'h0, "mcycle_wrap");
    instret_pulse = 1'b1;
    csr_op(12'hB02, 3'b001, 5'd1, 64'h100, 1'b0, 64'h0, "minstret_wr");
    csr_op(12'hC02, 3'b010, 5'd0, 64'h0, 1'b0, 64'h100, "minstret_held");
    instret_pulse = 1'b0;
    csr_op(12'hB02, 3'b010, 5'd0, 64'h0, 1'b0, 64'h101, "minstret_inc");

    timer_irq = 1'b1;
    csr_op(12'h344, 3'b010, 5'd0, 64'h0, 1'b0, 64'h80, "mip.read");
    check("mip.out", mip, 64'h80);
    timer_irq = 1'b0;

    // Mid-cycle reset from U-mode with a write in flight.
    xret_valid = 1'b1; xret_new_mstatus = 64'h88; xret_new_priv = 2'b00;
    @(posedge clk); #1; xret_valid = 1'b0;
    check("pre_rst.priv", 64'(privilege_mode), 64'd0);
    csr_instr_valid = 1'b1; csr_addr = 12'h340; csr_funct3 = 3'b001; csr_rs1_data = 64'h1234;
    #2 rst = 1'b0;
    #1;
    check("rst.priv_async", 64'(privilege_mode), 64'd3);
    check("rst.mstatus", mstatus, 64'h0);
    check("rst.mepc", mepc, 64'h0);
    check("rst.mtvec_async", mtvec, 64'h0);
    check("rst.mie", mie, 64'h0);
    @(posedge clk); #1; csr_instr_valid = 1'b0;
    reset_release();
    csr_op(12'h340, 3'b010, 5'd0, 64'h0, 1'b0, 64'h0, "rst.mscratch");
    csr_op(12'hB00, 3'b010, 5'd0, 64'h0, 1'b0, exp_cycle, "rst.mcycle");
    csr_op(12'hB02, 3'b010, 5'd0, 64'h0, 1'b0, 64'h0, "rst.minstret");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
